// File: rtl/guess_scorer.sv
// Sequential bulls-and-cows scorer: latches target/guess on start, scans digit pairs one per cycle.
// Build option: define DUP_SAFE_EN for the duplicate-correct two-pass (EXACT then NEAR) algorithm.
module guess_scorer #(
  parameter int DIGITS = 4,
  parameter int DW     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DIGITS*DW-1:0] target_in,
  input  logic [DIGITS*DW-1:0] guess_in,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           exact_cnt,
  output logic [2:0]           near_cnt,
  output logic                 win
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [2:0]    CMAX = 3'(DIGITS);

  typedef enum logic [1:0] {IDLE, EXACT, NEAR, DONE} state_t;

  state_t               state_q, state_d;
  logic [DIGITS*DW-1:0] t_q, t_d, g_q, g_d;
  logic [IW-1:0]        i_q, i_d, j_q, j_d;
  logic [2:0]           exact_q, exact_d, near_q, near_d;
  logic [2:0]           exact_cnt_q, exact_cnt_d, near_cnt_q, near_cnt_d;
  logic                 win_q, win_d;
`ifdef DUP_SAFE_EN
  logic [DIGITS-1:0]    t_used_q, t_used_d, g_used_q, g_used_d;
`endif

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v >= CMAX) ? CMAX : v + 3'd1;
  endfunction

  function automatic logic [DW-1:0] dig(input logic [DIGITS*DW-1:0] v, input logic [IW-1:0] k);
    return v[k*DW +: DW];
  endfunction

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    g_d         = g_q;
    i_d         = i_q;
    j_d         = j_q;
    exact_d     = exact_q;
    near_d      = near_q;
    exact_cnt_d = exact_cnt_q;
    near_cnt_d  = near_cnt_q;
    win_d       = win_q;
`ifdef DUP_SAFE_EN
    t_used_d    = t_used_q;
    g_used_d    = g_used_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          t_d     = target_in;
          g_d     = guess_in;
          exact_d = '0;
          near_d  = '0;
          i_d     = '0;
          j_d     = '0;
`ifdef DUP_SAFE_EN
          t_used_d = '0;
          g_used_d = '0;
          state_d  = EXACT;
`else
          state_d  = NEAR;
`endif
        end
      end
`ifdef DUP_SAFE_EN
      EXACT: begin
        if (dig(t_q, i_q) == dig(g_q, i_q)) begin
          exact_d       = sat_inc(exact_q);
          t_used_d[i_q] = 1'b1;
          g_used_d[i_q] = 1'b1;
        end
        if (i_q == LAST) begin
          i_d     = '0;
          state_d = NEAR;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
`endif
      NEAR: begin
`ifdef DUP_SAFE_EN
        if (!g_used_q[j_q] && !t_used_q[i_q] && dig(g_q, j_q) == dig(t_q, i_q)) begin
          near_d        = sat_inc(near_q);
          t_used_d[i_q] = 1'b1;
          g_used_d[j_q] = 1'b1;
        end
`else
        if (dig(g_q, j_q) == dig(t_q, i_q)) begin
          if (i_q == j_q) exact_d = sat_inc(exact_q);
          else            near_d  = sat_inc(near_q);
        end
`endif
        if (i_q == LAST) begin
          i_d = '0;
          if (j_q == LAST) begin
            j_d     = '0;
            state_d = DONE;
            // Results land on the edge into DONE so they are valid while done is high
            exact_cnt_d = exact_d;
            near_cnt_d  = near_d;
            win_d       = (exact_d == CMAX);
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      t_q         <= '0;
      g_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      exact_q     <= '0;
      near_q      <= '0;
      exact_cnt_q <= '0;
      near_cnt_q  <= '0;
      win_q       <= 1'b0;
`ifdef DUP_SAFE_EN
      t_used_q    <= '0;
      g_used_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      g_q         <= g_d;
      i_q         <= i_d;
      j_q         <= j_d;
      exact_q     <= exact_d;
      near_q      <= near_d;
      exact_cnt_q <= exact_cnt_d;
      near_cnt_q  <= near_cnt_d;
      win_q       <= win_d;
`ifdef DUP_SAFE_EN
      t_used_q    <= t_used_d;
      g_used_q    <= g_used_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign exact_cnt = exact_cnt_q;
  assign near_cnt  = near_cnt_q;
  assign win       = win_q;
endmodule

// File: tb/tb_guess_scorer.sv
// Directed bench for guess_scorer; expectations follow the DUP_SAFE_EN build selection.
module tb_guess_scorer;
`ifdef DUP_SAFE_EN
  localparam int LAT   = 21;
  localparam int NEAR4 = 2;
`else
  localparam int LAT   = 17;
  localparam int NEAR4 = 4;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] target_in, guess_in;
  logic        busy, done, win;
  logic [2:0]  exact_cnt, near_cnt;
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  guess_scorer #(.DIGITS(4), .DW(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .target_in(target_in), .guess_in(guess_in),
    .busy(busy), .done(done), .exact_cnt(exact_cnt),
    .near_cnt(near_cnt), .win(win)
  );

  // Called at edge+1; leaves the bench one cycle after the start edge (scan cycle 1).
  task automatic launch(input logic [15:0] t, input logic [15:0] g);
    target_in = t;
    guess_in  = g;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    target_in = ~t;
    guess_in  = 16'h9999;
  endtask

  // Observes cycles k0..k0+n-1; reports done pulses, last done cycle and outputs at it.
  task automatic watch(input int k0, input int n, output int nd, output int at,
                       output logic [2:0] e, output logic [2:0] nr, output logic w);
    nd = 0; at = -1; e = 3'd7; nr = 3'd7; w = 1'bx;
    for (int k = k0; k < k0 + n; k++) begin
      if (done === 1'b1) begin
        nd++; at = k; e = exact_cnt; nr = near_cnt; w = win;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; target_in = '0; guess_in = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0)      $display("FAIL reset_busy got %b want 0", busy);       else passed++;
    total++; if (done !== 1'b0)      $display("FAIL reset_done got %b want 0", done);       else passed++;
    total++; if (exact_cnt !== 3'd0) $display("FAIL reset_exact got %0d want 0", exact_cnt); else passed++;
    total++; if (near_cnt !== 3'd0)  $display("FAIL reset_near got %0d want 0", near_cnt);  else passed++;
    total++; if (win !== 1'b0)       $display("FAIL reset_win got %b want 0", win);         else passed++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vector(input string name, input logic [15:0] t, input logic [15:0] g,
                             input logic [2:0] ee, input logic [2:0] en, input logic ew);
    int nd, at; logic [2:0] e, nr; logic w;
    launch(t, g);
    total++; if (busy !== 1'b1) $display("FAIL %s_busy got %b want 1", name, busy); else passed++;
    watch(1, LAT + 3, nd, at, e, nr, w);
    total++; if (nd !== 1)   $display("FAIL %s_done_count got %0d want 1", name, nd);  else passed++;
    total++; if (at !== LAT) $display("FAIL %s_latency got %0d want %0d", name, at, LAT); else passed++;
    total++; if (e !== ee)   $display("FAIL %s_exact got %0d want %0d", name, e, ee);  else passed++;
    total++; if (nr !== en)  $display("FAIL %s_near got %0d want %0d", name, nr, en);  else passed++;
    total++; if (w !== ew)   $display("FAIL %s_win got %b want %b", name, w, ew);      else passed++;
    total++; if (busy !== 1'b0) $display("FAIL %s_idle_busy got %b want 0", name, busy); else passed++;
    total++; if (exact_cnt !== ee) $display("FAIL %s_hold_exact got %0d want %0d", name, exact_cnt, ee); else passed++;
  endtask

  task automatic test_back_to_back();
    int nd1, at1, nd2, at2, nd3, at3; logic [2:0] e, nr, e2, nr2, e3, nr3; logic w, w2, w3;
    launch(16'h1234, 16'h4321);
    watch(1, 4, nd1, at1, e, nr, w);
    total++; if (exact_cnt !== 3'd1) $display("FAIL b2b_midscan_exact got %0d want 1", exact_cnt); else passed++;
    total++; if (near_cnt !== 3'(NEAR4)) $display("FAIL b2b_midscan_near got %0d want %0d", near_cnt, NEAR4); else passed++;
    start = 1'b1; guess_in = 16'h1234; target_in = 16'h1234;
    watch(5, 1, nd2, at2, e2, nr2, w2);
    start = 1'b0;
    watch(6, LAT - 5, nd3, at3, e3, nr3, w3);
    total++; if (nd1 + nd2 + nd3 !== 1) $display("FAIL b2b_done_count got %0d want 1", nd1 + nd2 + nd3); else passed++;
    total++; if (at3 !== LAT) $display("FAIL b2b_latency got %0d want %0d", at3, LAT); else passed++;
    total++; if (e3 !== 3'd0) $display("FAIL b2b_exact got %0d want 0", e3); else passed++;
    total++; if (nr3 !== 3'd4) $display("FAIL b2b_near got %0d want 4", nr3); else passed++;
    total++; if (w3 !== 1'b0) $display("FAIL b2b_win got %b want 0", w3); else passed++;
    // Now in the cycle right after done: a new start must be accepted
    launch(16'h1234, 16'h1234);
    watch(1, LAT + 2, nd1, at1, e, nr, w);
    total++; if (nd1 !== 1) $display("FAIL b2b_restart_done got %0d want 1", nd1); else passed++;
    total++; if (at1 !== LAT) $display("FAIL b2b_restart_latency got %0d want %0d", at1, LAT); else passed++;
    total++; if (e !== 3'd4 || w !== 1'b1) $display("FAIL b2b_restart_result got e=%0d w=%b want e=4 w=1", e, w); else passed++;
  endtask

  task automatic test_reset_mid();
    int nd, at; logic [2:0] e, nr; logic w;
    launch(16'h1234, 16'h4321);
    watch(1, 7, nd, at, e, nr, w);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else passed++;
    total++; if (exact_cnt !== 3'd0 || near_cnt !== 3'd0) $display("FAIL rmid_counts got %0d/%0d want 0/0", exact_cnt, near_cnt); else passed++;
    total++; if (win !== 1'b0) $display("FAIL rmid_win got %b want 0", win); else passed++;
    watch(1, LAT + 2, nd, at, e, nr, w);
    total++; if (nd !== 0) $display("FAIL rmid_no_done got %0d want 0", nd); else passed++;
    test_vector("rmid_fresh", 16'h1234, 16'h1243, 3'd2, 3'd2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_vector("same",     16'h1234, 16'h1234, 3'd4, 3'd0, 1'b1);
    test_vector("reversed", 16'h1234, 16'h4321, 3'd0, 3'd4, 1'b0);
    test_vector("disjoint", 16'h1234, 16'h5678, 3'd0, 3'd0, 1'b0);
    test_vector("dups",     16'h1123, 16'h1211, 3'd1, 3'(NEAR4), 1'b0);
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
